// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_LANES  = DMEM_DATA_W / 8;
  localparam int unsigned DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  // Merge new data into an old word, one byte lane per enable bit
  function automatic logic [DMEM_DATA_W-1:0] dmem_merge(
    input logic [DMEM_DATA_W-1:0] old_w,
    input logic [DMEM_DATA_W-1:0] new_w,
    input logic [DMEM_LANES-1:0]  be
  );
    logic [DMEM_DATA_W-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < DMEM_LANES; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous byte-masked write, registered read
// whose output holds until the next read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DMEM_LANES-1:0] i_be,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= dmem_merge(r_mem[i_idx], i_wdata, i_be);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and a ready pulse.
// Optional byte-lane write mask enabled by DMEM_BYTEMASK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
`ifdef DMEM_BYTEMASK_EN
  input  logic [DMEM_LANES-1:0] wstrb,
`endif
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  dmem_state_e             r_state;
  logic [DMEM_CNT_W-1:0]   r_cnt;
  logic                    r_is_wr;
  logic [ADDR_W-1:0]       r_idx;
  logic [DATA_W-1:0]       r_wdata;
  logic [DMEM_LANES-1:0]   r_be;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_err;

  logic                    w_req_ok;
  logic                    w_req_bad;
  logic                    w_commit;
  logic [DMEM_LANES-1:0]   w_be_in;
  logic                    w_addr_unused;

`ifdef DMEM_BYTEMASK_EN
  assign w_be_in = wstrb;
`else
  assign w_be_in = '1;
`endif

  // Upper byte-address bits are dropped so the index wraps modulo depth
  assign w_addr_unused = ^addr[31:ADDR_W+2];

  assign w_req_ok  = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
  assign w_req_bad = (MemRead && MemWrite) ||
                     ((MemRead || MemWrite) && (addr[1:0] != 2'b00));
  assign w_commit  = (r_state == S_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            r_is_wr <= MemWrite;
            r_idx   <= addr[ADDR_W+1:2];
            r_wdata <= wdata;
            r_be    <= w_be_in;
            r_cnt   <= DMEM_CNT_W'(WAIT_CYC);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end else if (w_req_bad) begin
            r_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          // The array commits in this same cycle when the count reaches zero
          if (r_cnt == '0) begin
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_commit && r_is_wr),
    .i_re    (w_commit && !r_is_wr),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (rdata)
  );

  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule
